// File: rtl/core_dispatch_ctrl.sv
// Dispatch sequencer: walks a programmable address table, issues each entry to every core,
// waits for all cores to report done, and guards each dispatch with a watchdog.
module core_dispatch_ctrl #(
  parameter int N_CORES  = 4,
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 64,
  parameter int MIN_WAIT = 2,
  parameter int TMO_W    = 16,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tbl_we,
  input  logic [PTR_W-1:0]   tbl_waddr,
  input  logic [ADDR_W-1:0]  tbl_wdata,
  input  logic [PTR_W:0]     num_addr,
  input  logic               start,
  input  logic [N_CORES-1:0] core_done,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               core_start,
  output logic               busy,
  output logic [PTR_W:0]     idx,
  output logic               done,
  output logic               timeout
);
  localparam int WCNT_W = (MIN_WAIT < 1) ? 1 : $clog2(MIN_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MIN = WCNT_W'(MIN_WAIT);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  // The counter reaching all-ones is the expiry event, so we fire one count early.
  localparam logic [TMO_W-1:0]  TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]    IDX_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]    NUM_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rdata_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W:0]    num_reg, idx_reg, idx_inc;
  logic [WCNT_W-1:0] wcnt_reg;
  logic [TMO_W-1:0]  tcnt_reg;
  logic              core_start_reg, timeout_reg;
  logic              all_done, last_entry, tmo_hit;
  logic              go, issue, complete, tmo_fire;

  assign all_done   = &core_done;
  assign idx_inc    = idx_reg + IDX_ONE;
  assign last_entry = (idx_inc == num_reg);
  assign tmo_hit    = (tcnt_reg == TMO_LAST);

  assign addr_out   = addr_reg;
  assign core_start = core_start_reg;
  assign idx        = idx_reg;
  assign timeout    = timeout_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (start) state_next = S_FETCH;
      S_FETCH:        state_next = S_ISSUE;
      S_ISSUE: begin
        if (issue)         state_next = S_WAIT;
        else if (tmo_fire) state_next = S_DONE;
      end
      S_WAIT: begin
        if (complete)      state_next = last_entry ? S_DONE : S_FETCH;
        else if (tmo_fire) state_next = S_DONE;
      end
      default:        state_next = S_IDLE;
    endcase
  end

  always_comb begin
    go       = 1'b0;
    issue    = 1'b0;
    complete = 1'b0;
    tmo_fire = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_reg)
      S_IDLE:  go = start;
      S_FETCH: busy = 1'b1;
      S_ISSUE: begin
        busy     = 1'b1;
        issue    = all_done;
        tmo_fire = !all_done && tmo_hit;
      end
      S_WAIT: begin
        busy     = 1'b1;
        complete = (wcnt_reg >= WCNT_MIN) && all_done;
        tmo_fire = !complete && tmo_hit;
      end
      S_DONE: begin
        done = 1'b1;
        go   = start;
      end
      default: ;
    endcase
  end

  // Table is never reset so a loaded program survives a controller reset.
  always_ff @(posedge clk) begin
    if (tbl_we) mem[tbl_waddr] <= tbl_wdata;
    if (state_reg == S_FETCH) rdata_reg <= mem[ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg       <= '0;
      core_start_reg <= 1'b0;
      ptr_reg        <= '0;
      num_reg        <= '0;
      idx_reg        <= '0;
      wcnt_reg       <= '0;
      tcnt_reg       <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      core_start_reg <= issue;
      if (go) begin
        num_reg     <= (num_addr == '0) ? NUM_FULL : num_addr;
        ptr_reg     <= '0;
        idx_reg     <= '0;
        tcnt_reg    <= '0;
        timeout_reg <= 1'b0;
      end
      if (issue) begin
        addr_reg <= rdata_reg;
        wcnt_reg <= '0;
        tcnt_reg <= '0;
      end else if (state_reg == S_ISSUE || state_reg == S_WAIT) begin
        tcnt_reg <= tcnt_reg + TMO_ONE;
      end
      if (state_reg == S_WAIT && wcnt_reg < WCNT_MIN) wcnt_reg <= wcnt_reg + WCNT_ONE;
      if (complete) begin
        idx_reg <= idx_inc;
        ptr_reg <= ptr_reg + PTR_ONE;
      end
      if (tmo_fire) timeout_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_core_dispatch_ctrl.sv
// Bench for core_dispatch_ctrl: hand-computed vector table, timeout/reset sequences, and
// randomized jobs checked against an arithmetic dispatch-schedule model.
module tb_core_dispatch_ctrl;
  localparam int N_CORES = 4;
  localparam int ADDR_W  = 12;
  localparam int DEPTH   = 64;
  localparam int PTR_W   = 6;
  localparam int TMO_W   = 6;

  logic               clk = 1'b0;
  logic               rst, tbl_we, start;
  logic [PTR_W-1:0]   tbl_waddr;
  logic [ADDR_W-1:0]  tbl_wdata;
  logic [PTR_W:0]     num_addr;
  logic [N_CORES-1:0] core_done;
  logic [ADDR_W-1:0]  addr_out;
  logic               core_start, busy, done, timeout;
  logic [PTR_W:0]     idx;

  always #5 clk = ~clk;

  core_dispatch_ctrl #(
    .N_CORES(N_CORES), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MIN_WAIT(2), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
    .num_addr(num_addr), .start(start), .core_done(core_done), .addr_out(addr_out),
    .core_start(core_start), .busy(busy), .idx(idx), .done(done), .timeout(timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Core model: busy for lat_tab[k][i] cycles starting the cycle after the k-th core_start.
  int cnt [N_CORES];
  int lat_tab [DEPTH][N_CORES];
  int k_issue;
  bit pend;
  int stuck_issue = -1;
  int stuck_core  = 0;
  logic [ADDR_W-1:0] tbl_model [DEPTH];

  int pulse_t [$];
  logic [ADDR_W-1:0] pulse_a [$];
  int done_at, idx_at, tmo_at, busy_at;

  typedef struct {
    int num; int lat; int lat_c2; int pre_c2; int inj;
    int exp_pulses; int exp_t0; int exp_t1; int exp_last; int exp_done; int exp_idx;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N_CORES; i++) begin
      if (pend)
        cnt[i] = (k_issue == stuck_issue && i == stuck_core) ? (1 << 30) : lat_tab[k_issue % DEPTH][i];
      else if (cnt[i] > 0)
        cnt[i]--;
      core_done[i] = (cnt[i] == 0);
    end
    if (pend) k_issue++;
    pend = core_start;
  endtask

  task automatic core_reset();
    for (int i = 0; i < N_CORES; i++) cnt[i] = 0;
    core_done = '1;
    pend = 1'b0;
    k_issue = 0;
  endtask

  task automatic set_lat(input int lat, input int lat_c2);
    for (int k = 0; k < DEPTH; k++)
      for (int i = 0; i < N_CORES; i++) lat_tab[k][i] = (i == 2) ? lat_c2 : lat;
  endtask

  // Pulses start in the current cycle and records every core_start until done rises.
  task automatic run_job(input int n, input int inj_at, input int budget);
    pulse_t.delete();
    pulse_a.delete();
    done_at = -1; idx_at = 0; tmo_at = 0; busy_at = 0;
    start = 1'b1;
    num_addr = 7'(n);
    for (int c = 1; c <= budget; c++) begin
      step();
      start = (c == inj_at);
      if (core_start) begin
        pulse_t.push_back(c);
        pulse_a.push_back(addr_out);
      end
      if (done) begin
        done_at = c; idx_at = int'(idx); tmo_at = int'(timeout); busy_at = int'(busy);
        break;
      end
    end
    start = 1'b0;
    if (done_at < 0) begin
      n_tests++; n_fail++;
      $display("FAIL job_done_wait: done never rose within %0d cycles (n=%0d)", budget, n);
    end
    $display("[TB] job n=%0d pulses=%0d done_at=%0d idx=%0d timeout=%0d",
             n, pulse_t.size(), done_at, idx_at, tmo_at);
  endtask

  initial begin
    int eff, t, lmax, pmax, exp_done;
    int exp_t [$];

    rst = 1'b1; start = 1'b0; tbl_we = 1'b0; tbl_waddr = '0; tbl_wdata = '0; num_addr = '0;
    core_reset();
    step(); step();
    check("rst_addr_out", addr_out, 0);
    check("rst_core_start", core_start, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", idx, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      tbl_we = 1'b1; tbl_waddr = PTR_W'(i); tbl_wdata = ADDR_W'(12'h100 + i);
      tbl_model[i] = ADDR_W'(12'h100 + i);
      step();
    end
    tbl_we = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;

    // Watchdog: core 1 never finishes the second entry.
    core_reset(); set_lat(4, 4);
    stuck_issue = 1; stuck_core = 1;
    run_job(3, 0, 300);
    check("tmo_pulses", pulse_t.size(), 2);
    check("tmo_done_at", done_at, 74);
    check("tmo_flag", tmo_at, 1);
    check("tmo_idx", idx_at, 1);
    check("tmo_busy", busy_at, 0);
    stuck_issue = -1;

    // Reset in WAIT of the second entry.
    core_reset(); set_lat(4, 4);
    start = 1'b1; num_addr = 7'd3;
    for (int c = 1; c <= 13; c++) begin
      step();
      start = 1'b0;
    end
    check("mid_idx_before", idx, 1);
    check("mid_busy_before", busy, 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_idx", idx, 0);
    check("mid_rst_core_start", core_start, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_addr_out", addr_out, 0);
    check("mid_rst_timeout", timeout, 0);
    core_reset();
    step(); step();
    check("post_rst_idle", busy, 0);

    //          num lat c2 pre inj pulses t0 t1   last   done idx
    vecs[0] = '{4,  10, 10, 0, 0,  4,     3, 17,  'h103, 57,  4};
    vecs[1] = '{0,  1,  1,  0, 0,  64,    3, 8,   'h13F, 321, 64};
    vecs[2] = '{2,  10, 40, 0, 0,  2,     3, 47,  'h101, 89,  2};
    vecs[3] = '{64, 2,  2,  0, 0,  64,    3, 9,   'h13F, 385, 64};
    vecs[4] = '{3,  8,  8,  0, 5,  3,     3, 15,  'h102, 37,  3};
    vecs[5] = '{1,  3,  3,  6, 0,  1,     7, -1,  'h100, 12,  1};
    vecs[6] = '{1,  5,  5,  0, 0,  1,     3, -1,  'h100, 10,  1};
    for (int v = 0; v < 7; v++) begin
      core_reset();
      set_lat(vecs[v].lat, vecs[v].lat_c2);
      cnt[2] = vecs[v].pre_c2;
      core_done[2] = (vecs[v].pre_c2 == 0);
      run_job(vecs[v].num, vecs[v].inj, 3000);
      check($sformatf("vec%0d_pulses", v), pulse_t.size(), vecs[v].exp_pulses);
      if (pulse_t.size() > 0) begin
        check($sformatf("vec%0d_t0", v), pulse_t[0], vecs[v].exp_t0);
        check($sformatf("vec%0d_first_addr", v), pulse_a[0], 'h100);
        check($sformatf("vec%0d_last_addr", v), pulse_a[pulse_t.size()-1], vecs[v].exp_last);
      end
      if (vecs[v].exp_t1 >= 0 && pulse_t.size() > 1)
        check($sformatf("vec%0d_t1", v), pulse_t[1], vecs[v].exp_t1);
      check($sformatf("vec%0d_done_at", v), done_at, vecs[v].exp_done);
      check($sformatf("vec%0d_idx", v), idx_at, vecs[v].exp_idx);
      check($sformatf("vec%0d_timeout", v), tmo_at, 0);
    end

    // Randomized jobs against the schedule model.
    for (int r = 0; r < 12; r++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      eff = (n == 0) ? DEPTH : n;
      for (int i = 0; i < eff; i++) begin
        tbl_model[i] = ADDR_W'($urandom);
        tbl_we = 1'b1; tbl_waddr = PTR_W'(i); tbl_wdata = tbl_model[i];
        step();
      end
      tbl_we = 1'b0;
      core_reset();
      for (int k = 0; k < DEPTH; k++)
        for (int i = 0; i < N_CORES; i++) lat_tab[k][i] = int'($urandom_range(1, 20));
      pmax = 0;
      for (int i = 0; i < N_CORES; i++) begin
        cnt[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
        core_done[i] = (cnt[i] == 0);
        if (cnt[i] > pmax) pmax = cnt[i];
      end
      // Issue k appears one cycle after the ISSUE cycle in which every core is idle;
      // the next comes Lmax+4 cycles later; done follows the last issue by Lmax+2.
      exp_t.delete();
      t = ((pmax > 2) ? pmax : 2) + 1;
      exp_done = 0;
      for (int k = 0; k < eff; k++) begin
        lmax = 0;
        for (int i = 0; i < N_CORES; i++) if (lat_tab[k][i] > lmax) lmax = lat_tab[k][i];
        exp_t.push_back(t);
        exp_done = t + lmax + 2;
        t = t + lmax + 4;
      end
      run_job(n, 0, 3000);
      check($sformatf("rnd%0d_pulses", r), pulse_t.size(), eff);
      for (int k = 0; k < eff && k < pulse_t.size(); k++) begin
        check($sformatf("rnd%0d_t%0d", r, k), pulse_t[k], exp_t[k]);
        check($sformatf("rnd%0d_addr%0d", r, k), pulse_a[k], tbl_model[k]);
      end
      check($sformatf("rnd%0d_done_at", r), done_at, exp_done);
      check($sformatf("rnd%0d_idx", r), idx_at, eff);
      check($sformatf("rnd%0d_timeout", r), tmo_at, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
